// File: rtl/cv32e40p_popcnt_ft_ctrl_if.sv
// Operand request and voted-result response channels of the fault-tolerant popcount controller.
// Both channels transfer on a clock edge where valid and ready are both high; valid may not drop before that edge.
interface cv32e40p_popcnt_ft_ctrl_if #(
  parameter int LEN = 32
);
  logic           valid;
  logic           ready;
  logic [LEN-1:0] operand;
  logic [5:0]     result;
  logic           result_valid;
  logic           result_ready;
  logic           corrected;
  logic           uncorrectable;

  modport master (
    output valid, operand, result_ready,
    input  ready, result, result_valid, corrected, uncorrectable
  );

  modport slave (
    input  valid, operand, result_ready,
    output ready, result, result_valid, corrected, uncorrectable
  );
endinterface

// File: rtl/cv32e40p_popcnt_ft_ctrl.sv
// TMR controller for three popcount replicas: broadcasts the operand, votes the results,
// retries once on no majority and retires a replica that keeps losing votes.
module cv32e40p_popcnt_ft_ctrl #(
  parameter int LEN    = 32,
  parameter int THRESH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  cv32e40p_popcnt_ft_ctrl_if.slave bus,
  output logic [LEN-1:0]      op_o,
  input  logic [2:0][5:0]     rep_result_i,
  output logic [2:0]          disable_o,
  input  logic                clear_i,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    RETRY = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [LEN-1:0]  op_q;
  logic [5:0]      result_q;
  logic            corr_q;
  logic            unc_q;
  logic [2:0]      disable_q;
  logic [2:0][3:0] cnt_q;
  logic [2:0][3:0] cnt_d;

  logic       e01, e02, e12;
  logic       vote_ok;
  logic [5:0] vote_val;
  logic [2:0] minority;
  logic       decide;
  logic [2:0] inc;
  logic [2:0] trip;

  assign e01 = (rep_result_i[0] == rep_result_i[1]);
  assign e02 = (rep_result_i[0] == rep_result_i[2]);
  assign e12 = (rep_result_i[1] == rep_result_i[2]);

  // At most one replica is ever disabled, so the two-enabled cases are exhaustive.
  always_comb begin
    vote_ok  = 1'b0;
    vote_val = 6'd0;
    minority = 3'b000;
    if (disable_q == 3'b000) begin
      if (e01 && e02) begin
        vote_ok  = 1'b1;
        vote_val = rep_result_i[0];
      end else if (e01) begin
        vote_ok  = 1'b1;
        vote_val = rep_result_i[0];
        minority = 3'b100;
      end else if (e02) begin
        vote_ok  = 1'b1;
        vote_val = rep_result_i[0];
        minority = 3'b010;
      end else if (e12) begin
        vote_ok  = 1'b1;
        vote_val = rep_result_i[1];
        minority = 3'b001;
      end
    end else if (disable_q[0]) begin
      vote_ok  = e12;
      vote_val = rep_result_i[1];
    end else if (disable_q[1]) begin
      vote_ok  = e02;
      vote_val = rep_result_i[0];
    end else begin
      vote_ok  = e01;
      vote_val = rep_result_i[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.valid) state_d = EVAL;
      EVAL:    state_d = vote_ok ? OUT : RETRY;
      RETRY:   state_d = OUT;
      OUT:     if (bus.result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A result is committed on a successful first vote or unconditionally after the retry.
  assign decide = ((state_q == EVAL) && vote_ok) || (state_q == RETRY);
  assign inc    = (decide && vote_ok) ? minority : 3'b000;

  always_comb begin
    cnt_d = cnt_q;
    trip  = 3'b000;
    for (int k = 0; k < 3; k++) begin
      if (inc[k] && (cnt_q[k] != 4'hF)) cnt_d[k] = cnt_q[k] + 4'd1;
      trip[k] = inc[k] && (cnt_d[k] >= 4'(THRESH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      result_q  <= 6'd0;
      corr_q    <= 1'b0;
      unc_q     <= 1'b0;
      cnt_q     <= '0;
      disable_q <= 3'b000;
    end else begin
      if ((state_q == IDLE) && bus.valid) op_q <= bus.operand;
      if (decide) begin
        result_q <= vote_ok ? vote_val : 6'd0;
        unc_q    <= ~vote_ok;
      end else if ((state_q == OUT) && bus.result_ready) begin
        unc_q    <= 1'b0;
      end
      corr_q <= decide && vote_ok && (minority != 3'b000);
      // Clear has priority over a same-edge increment or disable.
      if (clear_i) begin
        cnt_q     <= '0;
        disable_q <= 3'b000;
      end else begin
        cnt_q <= cnt_d;
        if (disable_q == 3'b000) disable_q <= trip;
      end
    end
  end

  assign bus.ready         = (state_q == IDLE);
  assign bus.result_valid  = (state_q == OUT);
  assign bus.result        = result_q;
  assign bus.corrected     = corr_q;
  assign bus.uncorrectable = unc_q;
  assign op_o              = op_q;
  assign disable_o         = disable_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_cv32e40p_popcnt_ft_ctrl.sv
// Randomized bench for the TMR popcount controller against a vote-counting reference model.
module tb_cv32e40p_popcnt_ft_ctrl;
  localparam int LEN    = 32;
  localparam int THRESH = 4;

  logic            clk;
  logic            rst_n;
  logic [LEN-1:0]  op_o;
  logic [2:0][5:0] rep_result;
  logic [2:0]      disable_o;
  logic            clear_i;
  logic [1:0]      dbg_state;

  cv32e40p_popcnt_ft_ctrl_if #(.LEN(LEN)) bus ();

  cv32e40p_popcnt_ft_ctrl #(.LEN(LEN), .THRESH(THRESH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .op_o         (op_o),
    .rep_result_i (rep_result),
    .disable_o    (disable_o),
    .clear_i      (clear_i),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  // reference model state: per-replica minority-error counts and disable flags
  int         m_cnt[3];
  logic [2:0] m_dis;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    m_dis = 3'b000;
  endtask

  // Majority = a value held by more than half of the enabled replicas.
  task automatic model_vote(input logic [2:0][5:0] r, input logic [2:0] dis,
                            output bit ok, output logic [5:0] val, output int mi);
    int n_en;
    int m;
    n_en = 0;
    ok   = 0;
    val  = 6'd0;
    mi   = -1;
    for (int k = 0; k < 3; k++) if (!dis[k]) n_en++;
    for (int k = 0; k < 3; k++) begin
      if (!dis[k]) begin
        m = 0;
        for (int j = 0; j < 3; j++) if (!dis[j] && r[j] == r[k]) m++;
        if (2 * m > n_en) begin
          ok  = 1;
          val = r[k];
        end
      end
    end
    if (ok && n_en == 3)
      for (int k = 0; k < 3; k++) if (r[k] != val) mi = k;
  endtask

  task automatic model_inc(input int k);
    if (k >= 0) begin
      if (m_cnt[k] < 15) m_cnt[k]++;
      if (m_cnt[k] >= THRESH && m_dis == 3'b000) m_dis[k] = 1'b1;
    end
  endtask

  // driver: one full operation from accept to result handshake
  task automatic run_op(input logic [31:0] opnd, input logic [2:0][5:0] t1,
                        input logic [2:0][5:0] t2, input int stall, input bit clr);
    bit         ok;
    logic [5:0] val;
    int         mi;
    logic [5:0] exp_res;
    bit         exp_corr;
    check("ready_idle", 64'(bus.ready), 64'd1);
    bus.valid        = 1'b1;
    bus.operand      = opnd;
    bus.result_ready = 1'b0;
    rep_result       = t1;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    check("op_o_loaded", 64'(op_o), 64'(opnd));
    check("ready_busy", 64'(bus.ready), 64'd0);
    clear_i = clr;
    model_vote(t1, m_dis, ok, val, mi);
    @(posedge clk); #1;
    clear_i = 1'b0;
    if (ok) model_inc(mi);
    if (clr) model_reset();
    if (!ok) begin
      check("no_valid_in_retry", 64'(bus.result_valid), 64'd0);
      rep_result = t2;
      model_vote(t2, m_dis, ok, val, mi);
      @(posedge clk); #1;
      if (ok) model_inc(mi);
    end
    exp_res  = ok ? val : 6'd0;
    exp_corr = ok && (mi >= 0);
    check("result_valid", 64'(bus.result_valid), 64'd1);
    check("result", 64'(bus.result), 64'(exp_res));
    check("corrected", 64'(bus.corrected), 64'(exp_corr));
    check("uncorrectable", 64'(bus.uncorrectable), 64'(!ok));
    check("disable", 64'(disable_o), 64'(m_dis));
    for (int s = 0; s < stall; s++) begin
      bus.valid   = 1'b1;
      bus.operand = ~opnd;
      @(posedge clk); #1;
      check("stall_valid", 64'(bus.result_valid), 64'd1);
      check("stall_result", 64'(bus.result), 64'(exp_res));
      check("stall_unc", 64'(bus.uncorrectable), 64'(!ok));
      check("stall_corr_pulse", 64'(bus.corrected), 64'd0);
      check("stall_ready", 64'(bus.ready), 64'd0);
      check("stall_op_o", 64'(op_o), 64'(opnd));
    end
    bus.valid        = 1'b0;
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    check("post_hs_valid", 64'(bus.result_valid), 64'd0);
    check("post_hs_unc", 64'(bus.uncorrectable), 64'd0);
    check("post_hs_ready", 64'(bus.ready), 64'd1);
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    model_reset();
    check("clear_disable", 64'(disable_o), 64'd0);
  endtask

  function automatic logic [2:0][5:0] gen_reps(input logic [5:0] c);
    logic [2:0][5:0] r;
    logic [5:0]      w;
    int              k;
    int              mode;
    mode = $urandom_range(0, 9);
    k    = $urandom_range(0, 2);
    w    = c + 6'($urandom_range(1, 63));
    r    = {c, c, c};
    if (mode >= 5 && mode <= 7) r[k] = w;
    else if (mode == 8) r = {c + 6'd2, c + 6'd1, c};
    else if (mode == 9) begin
      r    = {w, w, w};
      r[k] = c;
    end
    return r;
  endfunction

  logic [2:0][5:0] good8;
  logic [2:0][5:0] bad1;
  logic [31:0]     rop;
  logic [5:0]      rc;
  logic [2:0][5:0] rt1, rt2;

  initial begin
    rst_n            = 1'b0;
    bus.valid        = 1'b0;
    bus.operand      = '0;
    bus.result_ready = 1'b0;
    rep_result       = '0;
    clear_i          = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_op_o", 64'(op_o), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_result_valid", 64'(bus.result_valid), 64'd0);
    check("rst_corrected", 64'(bus.corrected), 64'd0);
    check("rst_unc", 64'(bus.uncorrectable), 64'd0);
    check("rst_disable", 64'(disable_o), 64'd0);

    // all replicas agree
    run_op(32'hF0F0_F0F0, {6'd16, 6'd16, 6'd16}, {6'd16, 6'd16, 6'd16}, 0, 1'b0);

    // replica 1 stuck at 7 until it is retired
    good8 = {6'd8, 6'd8, 6'd8};
    bad1  = {6'd8, 6'd7, 6'd8};
    for (int i = 0; i < 4; i++) run_op(32'h0000_00FF, bad1, bad1, 0, 1'b0);
    check("disable_after_4", 64'(disable_o), 64'b010);

    // two enabled disagree twice
    run_op(32'h0000_0007, {6'd5, 6'd7, 6'd3}, {6'd5, 6'd7, 6'd3}, 0, 1'b0);
    check("unc_disable_kept", 64'(disable_o), 64'b010);

    // consumer back-pressure
    run_op(32'h0000_00FF, good8, good8, 5, 1'b0);

    // clear racing the threshold-reaching increment
    pulse_clear();
    for (int i = 0; i < 3; i++) run_op(32'h0000_00FF, bad1, bad1, 0, 1'b0);
    run_op(32'h0000_00FF, bad1, bad1, 0, 1'b1);
    check("clear_wins", 64'(disable_o), 64'b000);
    for (int i = 0; i < 3; i++) run_op(32'h0000_00FF, bad1, bad1, 0, 1'b0);
    check("counters_cleared", 64'(disable_o), 64'b000);

    // reset during OUT: 4th error trips the disable, then reset discards everything
    bus.valid   = 1'b1;
    bus.operand = 32'h0000_00FF;
    rep_result  = bad1;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", 64'(bus.result_valid), 64'd1);
    check("pre_rst_disable", 64'(disable_o), 64'b010);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.result_valid), 64'd0);
    check("midrst_result", 64'(bus.result), 64'd0);
    check("midrst_corr", 64'(bus.corrected), 64'd0);
    check("midrst_disable", 64'(disable_o), 64'd0);
    check("midrst_op_o", 64'(op_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("postrst_ready", 64'(bus.ready), 64'd1);
    check("postrst_valid", 64'(bus.result_valid), 64'd0);
    for (int i = 0; i < 3; i++) run_op(32'h0000_00FF, {6'd8, 6'd8, 6'd1}, good8, 0, 1'b0);
    check("postrst_counters", 64'(disable_o), 64'b000);

    // randomized operations
    for (int i = 0; i < 300; i++) begin
      rop = $urandom();
      rc  = 6'($countones(rop));
      rt1 = gen_reps(rc);
      rt2 = ($urandom_range(0, 1) == 1) ? rt1 : gen_reps(rc);
      run_op(rop, rt1, rt2, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
             ($urandom_range(0, 19) == 0));
    end

    // full-width operand
    pulse_clear();
    run_op(32'hFFFF_FFFF, {6'd32, 6'd32, 6'd32}, {6'd32, 6'd32, 6'd32}, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
